jk_reg_writer: RTL
==================

Name: jk_reg_writer

Overview:
- Drives J/K excitation for an external bank of WIDTH simple JK flip-flops from a write-request interface.
- Supports four operations: load, set-mask, clear-mask and toggle-mask.
- Reads back the bank's Q outputs after each write and retries with an absolute load on mismatch.
- Sits between the control sequencer and any JK-flop register in the sim model, so the J/K encoding lives in one place.

Parameters:
WIDTH, 8, number of JK flip-flops in the driven bank
MAX_RETRY, 3, corrective re-drives allowed after a verify mismatch (0 = no retry)

Ports:
clk  input  1  rising-edge clock, shared with the JK bank
_reset  input  1  asynchronous active-low reset
wr_req  input  1  write request; sampled only while busy=0
wr_op  input  2  0=LOAD, 1=SET, 2=CLEAR, 3=TOGGLE
wr_data  input  WIDTH  load value (LOAD) or bit mask (SET/CLEAR/TOGGLE)
q_in  input  WIDTH  Q readback from the JK bank
j  output  WIDTH  J inputs to the bank (registered)
k  output  WIDTH  K inputs to the bank (registered)
busy  output  1  high from accept until the operation finishes
done  output  1  one-cycle pulse: verify passed
err  output  1  one-cycle pulse: retries exhausted
err_bits  output  WIDTH  mismatch mask (expected ^ q_in) latched on the failing verify; held until the next accept

Behaviour:
- Reset (_reset low, asynchronous): state IDLE; j=0, k=0, busy=0, done=0, err=0, err_bits=0; retry count 0.
  - Reset mid-operation aborts immediately; j/k fall to 0 without waiting for a clock, so the bank holds.
- States: IDLE, DRIVE, VERIFY.
- IDLE: j=k=0. At edge E0 with wr_req=1:
  - capture op and data;
  - compute expected from the q_in snapshot at E0: LOAD=data, SET=q|data, CLEAR=q&~data, TOGGLE=q^data;
  - go to DRIVE with busy=1, retry count 0.
- DRIVE (one cycle): registered j/k valid for exactly one cycle.
  - First attempt: LOAD j=data, k=~data; SET j=data, k=0; CLEAR j=0, k=data; TOGGLE j=data, k=data.
  - Retry attempt: j=expected, k=~expected (absolute load, every op).
  - The bank updates at edge E1. The state then goes to VERIFY and j=k=0.
- VERIFY (one cycle): at edge E2, compare q_in to expected.
  - Match: done=1 for one cycle, busy=0, state IDLE.
  - Mismatch with retry count < MAX_RETRY: increment count, go to DRIVE (retry encoding).
  - Mismatch with count == MAX_RETRY: err=1 for one cycle, err_bits=expected^q_in, busy=0, state IDLE.
- Latency: a clean write takes 2 cycles accept-to-done (done visible after E2). Each retry adds 2 cycles. Worst case is 2*(MAX_RETRY+1).
- wr_req while busy=1 is ignored (no queueing, no error). A new request may be accepted at the edge after done/err (E3 at the earliest).
- done and err are never high in the same cycle. j and k are 0 in every state except DRIVE.
- Retry count width is clog2(MAX_RETRY+1), minimum 1 bit. It never wraps.
- TOGGLE with mask 0, or SET/CLEAR producing no change, still runs the full DRIVE/VERIFY sequence and pulses done.

Test Plan:
- LOAD 0xA5 into bank at 0x00 -> j=0xA5, k=0x5A for one cycle; bank=0xA5; done pulse 2 cycles after accept; err_bits=0.
- Bank 0x0F: SET 0x30 -> j=0x30, k=0x00, bank=0x3F, done. Then CLEAR 0x05 -> bank=0x3A. Then TOGGLE 0xFF -> j=k=0xFF, bank=0xC5, done.
- Force one bank bit stuck at 0, LOAD 0xFF with MAX_RETRY=3:
  - 4 DRIVE cycles, each j=0xFF, k=0x00;
  - err pulse 8 cycles after accept;
  - err_bits shows the stuck bit (e.g. 0x08).
- Transient fault on the first attempt only, TOGGLE 0x01 from 0x00 -> retry drives j=0x01, k=0xFE; done 4 cycles after accept; no err.
- Hold wr_req high continuously with LOAD 0x11 then data changing to 0x22 -> only the captured 0x11 is written; the second accept happens at the edge after done.
- Assert _reset low during DRIVE -> j=k=0 and busy=0 immediately (before the next edge); bank unchanged; no done/err pulse after release.

Source files
------------

// File: rtl/jk_reg_writer.sv
// Drives J/K for an external JK bank from write requests, verifies Q and re-drives as an absolute load on mismatch.
// 2 cycles accept-to-done, +2 per retry; wr_req is ignored while busy (no queueing).
module jk_reg_writer #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             wr_req,
    input  logic [1:0]       wr_op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);
    localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, VERIFY} state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            retry_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            retry_q    <= retry_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        retry_d    = retry_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_bits_d = err_bits_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d    = DRIVE;
                    retry_d    = '0;
                    err_bits_d = '0;
                    // expected result is taken from the bank snapshot at accept
                    case (wr_op)
                        OP_LOAD: begin
                            exp_d = wr_data;
                            j_d   = wr_data;
                            k_d   = ~wr_data;
                        end
                        OP_SET: begin
                            exp_d = q_in | wr_data;
                            j_d   = wr_data;
                        end
                        OP_CLEAR: begin
                            exp_d = q_in & ~wr_data;
                            k_d   = wr_data;
                        end
                        default: begin
                            exp_d = q_in ^ wr_data;
                            j_d   = wr_data;
                            k_d   = wr_data;
                        end
                    endcase
                end
            end
            DRIVE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                if (q_in == exp_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < CW'(MAX_RETRY)) begin
                    retry_d = retry_q + CW'(1);
                    j_d     = exp_q;
                    k_d     = ~exp_q;
                    state_d = DRIVE;
                end else begin
                    err_d      = 1'b1;
                    err_bits_d = exp_q ^ q_in;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign j        = j_q;
    assign k        = k_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_bits = err_bits_q;
endmodule
